// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the MEM-stage access sequencer: one request/ack
// transaction at a time, address/data/direction held for its duration.
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: issues one memory transaction per load/store,
// stalls the pipeline until ack, returns load data and flags alignment and
// timeout faults as bus errors.
module mem_access_ctrl #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     MemReadIn,
    input  logic                     MemWriteIn,
    input  logic [31:0]              AddrIn,
    input  logic [31:0]              WriteDataIn,
    mem_access_ctrl_if.master        bus,
    output logic [31:0]              ReadDataOut,
    output logic                     stall,
    output logic                     bus_error,
    output logic                     err_sticky
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;

    // Count value in the final allowed ACCESS cycle; count starts at 0.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             sticky_q, sticky_d;
    logic             rd_q, rd_d;       // current access is a pure load
    logic             req;
    logic             aligned;
    logic             stall_c;

    assign req     = MemReadIn | MemWriteIn;
    assign aligned = (AddrIn[1:0] == 2'b00);

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sticky_q <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            sticky_q <= sticky_d;
            rd_q     <= rd_d;
        end
    end

    // Next-state logic and decoded handshake outputs.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sticky_d    = sticky_q;
        rd_d        = rd_q;
        stall_c     = 1'b0;
        bus.mem_req = 1'b0;
        bus_error   = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = req;
                if (req) begin
                    // Read+write together behaves as a store.
                    rd_d = MemReadIn & ~MemWriteIn;
                    if (aligned) begin
                        addr_d  = AddrIn;
                        wdata_d = WriteDataIn;
                        we_d    = MemWriteIn;
                        count_d = '0;
                        state_d = ACCESS;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ACCESS: begin
                bus.mem_req = 1'b1;
                stall_c     = 1'b1;
                // Ack has priority over a coincident timeout.
                if (bus.mem_ack) begin
                    if (rd_q) rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else if (count_q == LAST) begin
                    state_d = ERROR;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Inputs still describe the finished access; ignore them.
                state_d = IDLE;
            end
            ERROR: begin
                bus_error = 1'b1;
                sticky_d  = 1'b1;
                if (rd_q) rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline must not be frozen while held in reset.
    assign stall = stall_c & rst_n;

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign ReadDataOut   = rdata_q;
    assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized transactions against a transaction-level model of
// the MEM-stage sequencer.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadIn, MemWriteIn;
    logic [31:0] AddrIn, WriteDataIn;
    logic [31:0] ReadDataOut;
    logic        stall, bus_error, err_sticky;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what the pipeline should see after each transaction.
    logic [31:0] exp_rdo;
    logic        exp_sticky;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.CNT_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemReadIn   (MemReadIn),
        .MemWriteIn  (MemWriteIn),
        .AddrIn      (AddrIn),
        .WriteDataIn (WriteDataIn),
        .bus         (bus_if),
        .ReadDataOut (ReadDataOut),
        .stall       (stall),
        .bus_error   (bus_error),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline access. ack_at: ACCESS cycle (1-based) carrying the ack;
    // 0 or > TIMEOUT means the memory never answers in time.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rdata);
        bit is_rd;
        bit mis;
        bit ok;
        int nacc;
        is_rd = rd & ~wr;
        mis   = (addr[1:0] != 2'b00);
        ok    = !mis && ack_at >= 1 && ack_at <= TIMEOUT;
        nacc  = mis ? 0 : (ok ? ack_at : TIMEOUT);

        // IDLE cycle: request seen, pipeline held combinationally.
        @(negedge clk);
        MemReadIn = rd; MemWriteIn = wr; AddrIn = addr; WriteDataIn = wdata;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_req", 32'(bus_if.mem_req), 32'd0);

        for (int k = 1; k <= nacc; k++) begin
            @(negedge clk);
            bus_if.mem_ack   = (k == ack_at);
            bus_if.mem_rdata = (k == ack_at) ? rdata : $urandom;
            #1;
            chk("acc_req", 32'(bus_if.mem_req), 32'd1);
            chk("acc_stall", 32'(stall), 32'd1);
            chk("acc_we", 32'(bus_if.mem_we), 32'(wr));
            chk("acc_addr", bus_if.mem_addr, addr);
            chk("acc_wdata", bus_if.mem_wdata, wdata);
            chk("acc_berr", 32'(bus_error), 32'd0);
        end

        // DONE or ERROR cycle; a stray ack here must be ignored.
        @(negedge clk);
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = $urandom;
        #1;
        if (ok && is_rd) exp_rdo = rdata;
        chk("end_stall", 32'(stall), 32'd0);
        chk("end_req", 32'(bus_if.mem_req), 32'd0);
        chk("end_berr", 32'(bus_error), 32'(!ok));
        chk("end_rdo", ReadDataOut, exp_rdo);
        if (!ok) begin
            exp_sticky = 1'b1;
            if (is_rd) exp_rdo = '0;
        end

        // Back in IDLE with no request; late ack must not start anything.
        @(negedge clk);
        MemReadIn = 1'b0; MemWriteIn = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = $urandom;
        #1;
        chk("post_stall", 32'(stall), 32'd0);
        chk("post_berr", 32'(bus_error), 32'd0);
        chk("post_sticky", 32'(err_sticky), 32'(exp_sticky));
        chk("post_rdo", ReadDataOut, exp_rdo);
        @(negedge clk);
        bus_if.mem_ack = 1'b0;
        #1;
        chk("post_req", 32'(bus_if.mem_req), 32'd0);
    endtask

    initial begin
        exp_rdo = '0; exp_sticky = 1'b0;
        MemReadIn = 1'b1; MemWriteIn = 1'b0; AddrIn = 32'h10; WriteDataIn = '0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0;
        rst_n = 1'b0;
        #1;
        // Reset state; request is present but stall must be forced low.
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus_if.mem_req), 32'd0);
        chk("rst_addr", bus_if.mem_addr, 32'd0);
        chk("rst_rdo", ReadDataOut, 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_berr", 32'(bus_error), 32'd0);
        repeat (2) @(negedge clk);
        MemReadIn = 1'b0;
        rst_n = 1'b1;

        run_txn(1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF);           // zero-wait load
        run_txn(0, 1, 32'h24, 32'h12345678, 4, 32'hAAAA5555);    // store, 3 waits
        run_txn(1, 0, 32'h40, 32'h0, TIMEOUT, 32'hCAFEF00D);     // ack on last cycle
        run_txn(1, 1, 32'h44, 32'h0BADF00D, 2, 32'h11112222);    // read+write = store
        run_txn(1, 0, 32'h13, 32'h0, 1, 32'h5A5A5A5A);           // misaligned load
        run_txn(0, 1, 32'h22, 32'h77777777, 1, 32'h0);           // misaligned store
        run_txn(1, 0, 32'h80, 32'h0, 3, 32'h31415926);           // reload data
        run_txn(1, 0, 32'h84, 32'h0, 0, 32'h0);                  // timeout read

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            bit r, w;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            if (!r && !w) r = 1'b1;
            run_txn(r, w, a, $urandom, $urandom_range(0, TIMEOUT + 2), $urandom);
        end

        // Reset during ACCESS wait cycle 2.
        @(negedge clk);
        MemReadIn = 1'b1; MemWriteIn = 1'b0; AddrIn = 32'h100; bus_if.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_req_before", 32'(bus_if.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_if.mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_addr", bus_if.mem_addr, 32'd0);
        chk("mid_rst_rdo", ReadDataOut, 32'd0);
        chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
        @(negedge clk);
        MemReadIn = 1'b0;
        rst_n = 1'b1;
        exp_rdo = '0; exp_sticky = 1'b0;
        run_txn(1, 0, 32'h200, 32'h0, 2, 32'hFEEDFACE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access sequencer for the MIPS pipeline. Sits between the EX/MEM pipeline register outputs and a variable-latency data memory: it launches one request/acknowledge transaction per load or store, holds the pipeline with `stall` until the memory answers, and returns load data for write-back. It also detects misaligned word accesses and memory timeouts, and flags both as bus errors.

## Interface
Parameters:
- `CNT_W`, default 4: width of the wait counter.
- `TIMEOUT`, default 8: maximum number of ACCESS cycles before a timeout. Legal range is 1 .. 2^CNT_W-1.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `MemReadIn`  in  1  load request, taken from the EX/MEM MemtoReg output.
- `MemWriteIn`  in  1  store request, taken from the EX/MEM MemWrite output.
- `AddrIn`  in  32  byte address, taken from the EX/MEM ALUResult output.
- `WriteDataIn`  in  32  store data.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  latched address.
- `mem_wdata`  out  32  latched store data.
- `mem_rdata`  in  32  read data; valid only with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.
- `ReadDataOut`  out  32  load result for the MEM/WB register.
- `stall`  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `bus_error`  out  1  one-cycle pulse on a fault.
- `err_sticky`  out  1  latched fault flag; cleared only by reset.

## Operation
States: IDLE, ACCESS, DONE, ERROR.

**IDLE**
- Entered when `req = MemReadIn | MemWriteIn`.
- `stall = req` (combinational).
- If `req` is set and `AddrIn[1:0] == 0`:
  - Latch `mem_addr <= AddrIn`, `mem_wdata <= WriteDataIn`, `mem_we <= MemWriteIn`.
  - Clear the counter.
  - Go to ACCESS.
- If `req` is set and `AddrIn[1:0] != 0`: go to ERROR. No memory request is issued (alignment fault).
- If `MemReadIn` and `MemWriteIn` are both set, the access is treated as a write. `ReadDataOut` is unchanged.

**ACCESS**
- `mem_req = 1` and `stall = 1`.
- If `mem_ack` is high:
  - On a read, `ReadDataOut <= mem_rdata`.
  - Go to DONE.
- Else if `count == TIMEOUT-1`: go to ERROR.
- Else: `count <= count + 1`.
- If `mem_ack` arrives in the same cycle as the timeout, ack wins.

**DONE**
- `stall = 0` and `mem_req = 0`. The pipeline advances on this edge.
- Go unconditionally to IDLE. Inputs are ignored because they still describe the finished access.

**ERROR**
- `stall = 0`, `mem_req = 0`, `bus_error = 1`, `err_sticky <= 1`.
- On a faulting read, `ReadDataOut <= 0`.
- Go unconditionally to IDLE.

**Other rules**
- `mem_ack` is ignored in IDLE, DONE and ERROR.
- The counter saturates and never wraps, because `TIMEOUT <= 2^CNT_W-1`.

## Timing
**Reset** (`rst_n` low, takes effect immediately):
- state = IDLE, count = 0.
- `mem_req`, `mem_we`, `bus_error`, `err_sticky` = 0.
- `mem_addr`, `mem_wdata`, `ReadDataOut` = 0.
- `stall` is forced to 0 while `rst_n` is low.
- A reset during ACCESS drops the transaction: `mem_req` falls without waiting for ack.

**Output timing**
- `mem_req`, `stall` and `bus_error` are decoded from state and inputs.
- `mem_addr`, `mem_wdata`, `mem_we` and `ReadDataOut` are registered.

**Latency**
- A zero-wait access (ack in the first ACCESS cycle) takes 3 cycles: IDLE (stall), ACCESS (stall), DONE (release).
- Each additional wait cycle adds one stalled cycle.
- A timeout path spends exactly TIMEOUT cycles in ACCESS.
- `ReadDataOut` is valid from the DONE cycle until the next load completes.

**Spacing**
- There is no back-to-back issue from DONE or ERROR.
- A following access is first seen in IDLE on the next cycle.

## Test plan
1. **Zero-wait load.** `MemReadIn=1`, `AddrIn=0x10`, `mem_ack` high in the first ACCESS cycle with `mem_rdata=0xDEADBEEF`. Required: `stall` is 1 for 2 cycles, `mem_req` is 1 for 1 cycle with `mem_we=0`, then `ReadDataOut=0xDEADBEEF` in DONE with `stall=0`.
2. **Store with 3 wait cycles.** `MemWriteIn=1`, `AddrIn=0x24`, `WriteDataIn=0x12345678`, ack in the 4th ACCESS cycle. Required: `mem_we=1`, `mem_addr=0x24` and `mem_wdata=0x12345678` stable for 4 cycles, `stall` high for 5 cycles, `ReadDataOut` unchanged.
3. **Misaligned load.** `MemReadIn=1`, `AddrIn=0x13`. Required: `mem_req` never asserted, `bus_error` pulses one cycle after request, `err_sticky=1`, `ReadDataOut=0`.
4. **Timeout.** `TIMEOUT=8`, read with no ack. Required: `mem_req` high for exactly 8 cycles, then ERROR with a `bus_error` pulse. A late ack arriving in IDLE is ignored.
5. **Ack on the final allowed cycle.** Ack arrives in ACCESS cycle 8 with `TIMEOUT=8`. Required: DONE, not ERROR, and `err_sticky` stays 0.
6. **Reset mid-ACCESS.** Drive `rst_n` low during wait cycle 2. Required: `mem_req=0` and `stall=0` immediately, all registers at reset values, and a new access after release completes normally.
